// File: rtl/cheri_cap_xfer_pkg.sv
// Shared constants and types for the capability transfer engine and its checker.
package cheri_cap_xfer_pkg;

  localparam int NUM_BEATS   = 12;
  localparam int PERM_LC_BIT = 2;
  localparam int PERM_SC_BIT = 3;

  // Word offsets of each capability field in memory, lo word first.
  localparam int BEAT_BASE  = 0;
  localparam int BEAT_LEN   = 2;
  localparam int BEAT_CUR   = 4;
  localparam int BEAT_PERMS = 6;
  localparam int BEAT_ATTR  = 8;
  localparam int BEAT_TAG   = 10;

  typedef logic [2:0] fault_code_t;
  localparam fault_code_t FC_NONE     = 3'd0;
  localparam fault_code_t FC_UNTAGGED = 3'd1;
  localparam fault_code_t FC_PERM     = 3'd2;
  localparam fault_code_t FC_BOUNDS   = 3'd3;
  localparam fault_code_t FC_ALIGN    = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_XFER, ST_DONE} state_t;

  typedef logic [3:0] cnt_t;
  localparam cnt_t BEATS_C = cnt_t'(NUM_BEATS);

endpackage

// File: rtl/cheri_cap_check.sv
// Combinational effective-address and fault evaluation for a capability access.
module cheri_cap_check
  import cheri_cap_xfer_pkg::*;
#(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 24,
  parameter int OFF_W  = 10
) (
  input  logic              store,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] cur,
  input  logic [DATA_W-1:0] perms,
  input  logic              tag,
  input  logic [OFF_W-1:0]  off,
  output logic [ADDR_W-1:0] ea,
  output logic              fault,
  output fault_code_t       fault_code
);

  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(NUM_BEATS);

  logic [ADDR_W:0] ea_ext;
  logic [ADDR_W:0] lo_ext;
  logic [ADDR_W:0] hi_ext;
  logic            perm_ok;
  logic            perms_unused;

  assign ea      = cur + {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
  // One extra bit so neither ea+12 nor base+len can wrap.
  assign ea_ext  = {1'b0, ea};
  assign lo_ext  = {1'b0, base};
  assign hi_ext  = {1'b0, base} + {1'b0, len};
  assign perm_ok = store ? perms[PERM_SC_BIT] : perms[PERM_LC_BIT];
  assign perms_unused = ^perms;

  always_comb begin
    fault_code = FC_NONE;
    if (!tag) begin
      fault_code = FC_UNTAGGED;
    end else if (!perm_ok) begin
      fault_code = FC_PERM;
    end else if (ea[0]) begin
      fault_code = FC_ALIGN;
    end else if ((ea_ext < lo_ext) || (ea_ext + SPAN > hi_ext)) begin
      fault_code = FC_BOUNDS;
    end
  end

  assign fault = (fault_code != FC_NONE);

endmodule

// File: rtl/cheri_cap_xfer.sv
// Multi-beat capability load/store engine: checks the authorising capability,
// then moves the 12-word capability image over the data-memory port.
module cheri_cap_xfer
  import cheri_cap_xfer_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int ADDR_W  = 48,
  parameter int OFF_W   = 10,
  parameter int MAX_OUT = 4
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_req_valid,
  output logic              ow_req_ready,
  input  logic              iw_req_store,
  input  logic [ADDR_W-1:0] iw_auth_base,
  input  logic [ADDR_W-1:0] iw_auth_len,
  input  logic [ADDR_W-1:0] iw_auth_cur,
  input  logic [DATA_W-1:0] iw_auth_perms,
  input  logic              iw_auth_tag,
  input  logic [OFF_W-1:0]  iw_off,
  input  logic [ADDR_W-1:0] iw_st_base,
  input  logic [ADDR_W-1:0] iw_st_len,
  input  logic [ADDR_W-1:0] iw_st_cur,
  input  logic [DATA_W-1:0] iw_st_perms,
  input  logic [DATA_W-1:0] iw_st_attr,
  input  logic              iw_st_tag,
  output logic              ow_mem_valid,
  input  logic              iw_mem_ready,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  input  logic              iw_mem_rvalid,
  input  logic [DATA_W-1:0] iw_mem_rdata,
  output logic              ow_done,
  output logic              ow_fault,
  output logic [2:0]        ow_fault_code,
  output logic [ADDR_W-1:0] ow_cap_base,
  output logic [ADDR_W-1:0] ow_cap_len,
  output logic [ADDR_W-1:0] ow_cap_cur,
  output logic [DATA_W-1:0] ow_cap_perms,
  output logic [DATA_W-1:0] ow_cap_attr,
  output logic              ow_cap_tag
);

  localparam cnt_t MAX_OUT_C = cnt_t'(MAX_OUT);

  state_t                             state_reg;
  logic                               store_reg;
  logic [ADDR_W-1:0]                  auth_base_reg, auth_len_reg, auth_cur_reg, ea_reg;
  logic [DATA_W-1:0]                  auth_perms_reg;
  logic                               auth_tag_reg;
  logic [OFF_W-1:0]                   off_reg;
  logic [ADDR_W-1:0]                  st_base_reg, st_len_reg, st_cur_reg;
  logic [DATA_W-1:0]                  st_perms_reg, st_attr_reg;
  logic                               st_tag_reg;
  cnt_t                               issue_cnt_reg, recv_cnt_reg, out_cnt_reg;
  cnt_t                               issue_next, recv_next, out_next;
  logic                               mem_valid_reg, mem_we_reg;
  logic [ADDR_W-1:0]                  mem_addr_reg;
  logic [DATA_W-1:0]                  mem_wdata_reg;
  logic                               done_reg, fault_reg;
  fault_code_t                        fault_code_reg;
  logic [ADDR_W-1:0]                  cap_base_reg, cap_len_reg, cap_cur_reg;
  logic [DATA_W-1:0]                  cap_perms_reg, cap_attr_reg;
  logic                               cap_tag_reg;
  logic [DATA_W-1:0]                  shadow [NUM_BEATS];
  logic [NUM_BEATS-1:0][DATA_W-1:0]   st_words;
  logic                               fire, rx, chk_fault, shadow_unused;
  logic [ADDR_W-1:0]                  chk_ea;
  fault_code_t                        chk_code;

  cheri_cap_check #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFF_W(OFF_W)) u_check (
    .store      (store_reg),
    .base       (auth_base_reg),
    .len        (auth_len_reg),
    .cur        (auth_cur_reg),
    .perms      (auth_perms_reg),
    .tag        (auth_tag_reg),
    .off        (off_reg),
    .ea         (chk_ea),
    .fault      (chk_fault),
    .fault_code (chk_code)
  );

  // Memory image of the capability being stored; upper halves of narrow fields are zero.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_addr_words
    assign st_words[BEAT_BASE+gi] = st_base_reg[gi*DATA_W +: DATA_W];
    assign st_words[BEAT_LEN+gi]  = st_len_reg[gi*DATA_W +: DATA_W];
    assign st_words[BEAT_CUR+gi]  = st_cur_reg[gi*DATA_W +: DATA_W];
  end
  assign st_words[BEAT_PERMS]   = st_perms_reg;
  assign st_words[BEAT_PERMS+1] = '0;
  assign st_words[BEAT_ATTR]    = st_attr_reg;
  assign st_words[BEAT_ATTR+1]  = '0;
  assign st_words[BEAT_TAG]     = DATA_W'(st_tag_reg);
  assign st_words[BEAT_TAG+1]   = '0;

  assign fire       = mem_valid_reg && iw_mem_ready;
  assign rx         = (state_reg == ST_XFER) && !store_reg && iw_mem_rvalid && (recv_cnt_reg < BEATS_C);
  assign issue_next = issue_cnt_reg + cnt_t'(fire);
  assign recv_next  = recv_cnt_reg + cnt_t'(rx);
  assign out_next   = out_cnt_reg + cnt_t'(fire) - cnt_t'(rx);

  always_ff @(posedge iw_clk) begin
    if (rx) shadow[recv_cnt_reg] <= iw_mem_rdata;
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_reg      <= ST_IDLE;
      store_reg      <= 1'b0;
      auth_base_reg  <= '0;
      auth_len_reg   <= '0;
      auth_cur_reg   <= '0;
      auth_perms_reg <= '0;
      auth_tag_reg   <= 1'b0;
      off_reg        <= '0;
      st_base_reg    <= '0;
      st_len_reg     <= '0;
      st_cur_reg     <= '0;
      st_perms_reg   <= '0;
      st_attr_reg    <= '0;
      st_tag_reg     <= 1'b0;
      ea_reg         <= '0;
      issue_cnt_reg  <= '0;
      recv_cnt_reg   <= '0;
      out_cnt_reg    <= '0;
      mem_valid_reg  <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      done_reg       <= 1'b0;
      fault_reg      <= 1'b0;
      fault_code_reg <= FC_NONE;
      cap_base_reg   <= '0;
      cap_len_reg    <= '0;
      cap_cur_reg    <= '0;
      cap_perms_reg  <= '0;
      cap_attr_reg   <= '0;
      cap_tag_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (iw_req_valid) begin
            store_reg      <= iw_req_store;
            auth_base_reg  <= iw_auth_base;
            auth_len_reg   <= iw_auth_len;
            auth_cur_reg   <= iw_auth_cur;
            auth_perms_reg <= iw_auth_perms;
            auth_tag_reg   <= iw_auth_tag;
            off_reg        <= iw_off;
            st_base_reg    <= iw_st_base;
            st_len_reg     <= iw_st_len;
            st_cur_reg     <= iw_st_cur;
            st_perms_reg   <= iw_st_perms;
            st_attr_reg    <= iw_st_attr;
            st_tag_reg     <= iw_st_tag;
            fault_reg      <= 1'b0;
            fault_code_reg <= FC_NONE;
            state_reg      <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          issue_cnt_reg  <= '0;
          recv_cnt_reg   <= '0;
          out_cnt_reg    <= '0;
          fault_reg      <= chk_fault;
          fault_code_reg <= chk_code;
          if (chk_fault) begin
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            ea_reg        <= chk_ea;
            mem_addr_reg  <= chk_ea;
            mem_wdata_reg <= st_words[0];
            mem_we_reg    <= store_reg;
            mem_valid_reg <= 1'b1;
            state_reg     <= ST_XFER;
          end
        end
        ST_XFER: begin
          issue_cnt_reg <= issue_next;
          recv_cnt_reg  <= recv_next;
          out_cnt_reg   <= out_next;
          if (fire && (issue_next < BEATS_C)) begin
            mem_addr_reg  <= ea_reg + ADDR_W'(issue_next);
            mem_wdata_reg <= st_words[issue_next];
          end
          if (store_reg) begin
            mem_valid_reg <= (issue_next < BEATS_C);
            if (issue_next == BEATS_C) begin
              mem_we_reg <= 1'b0;
              done_reg   <= 1'b1;
              state_reg  <= ST_DONE;
            end
          end else begin
            // Reads stay pipelined up to MAX_OUT accepted-but-unreturned beats.
            mem_valid_reg <= (issue_next < BEATS_C) && (out_next < MAX_OUT_C);
            if (recv_next == BEATS_C) begin
              // The last beat is the tag hi word, so all used fields are already captured.
              cap_base_reg  <= {shadow[BEAT_BASE+1], shadow[BEAT_BASE]};
              cap_len_reg   <= {shadow[BEAT_LEN+1], shadow[BEAT_LEN]};
              cap_cur_reg   <= {shadow[BEAT_CUR+1], shadow[BEAT_CUR]};
              cap_perms_reg <= shadow[BEAT_PERMS];
              cap_attr_reg  <= shadow[BEAT_ATTR];
              cap_tag_reg   <= shadow[BEAT_TAG][0];
              done_reg      <= 1'b1;
              state_reg     <= ST_DONE;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign shadow_unused = ^{shadow[BEAT_PERMS+1], shadow[BEAT_ATTR+1], shadow[BEAT_TAG+1],
                           shadow[BEAT_TAG][DATA_W-1:1]};

  assign ow_req_ready  = (state_reg == ST_IDLE);
  assign ow_mem_valid  = mem_valid_reg;
  assign ow_mem_we     = mem_we_reg;
  assign ow_mem_addr   = mem_addr_reg;
  assign ow_mem_wdata  = mem_wdata_reg;
  assign ow_done       = done_reg;
  assign ow_fault      = fault_reg;
  assign ow_fault_code = fault_code_reg;
  assign ow_cap_base   = cap_base_reg;
  assign ow_cap_len    = cap_len_reg;
  assign ow_cap_cur    = cap_cur_reg;
  assign ow_cap_perms  = cap_perms_reg;
  assign ow_cap_attr   = cap_attr_reg;
  assign ow_cap_tag    = cap_tag_reg;

endmodule
